// File: rtl/stopwatch_timer_datapath_if.sv
// rtl/stopwatch_timer_datapath_if.sv - control and time bus between button controller, time core and display
interface stopwatch_timer_datapath_if;
    logic       run;
    logic       clear;
    logic       mode;
    logic       set_en;
    logic [1:0] set_sel;
    logic       inc;
    logic       dec;
    logic       lap;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [6:0] lap_msec;
    logic [5:0] lap_sec;
    logic [5:0] lap_min;
    logic [4:0] lap_hour;
    logic       lap_valid;
    logic       done;
    logic       overflow;
    logic       running;

    modport master (
        output run, clear, mode, set_en, set_sel, inc, dec, lap,
        input  msec, sec, min, hour, lap_msec, lap_sec, lap_min, lap_hour,
        input  lap_valid, done, overflow, running
    );

    modport slave (
        input  run, clear, mode, set_en, set_sel, inc, dec, lap,
        output msec, sec, min, hour, lap_msec, lap_sec, lap_min, lap_hour,
        output lap_valid, done, overflow, running
    );
endinterface

// File: rtl/stopwatch_timer_datapath.sv
// rtl/stopwatch_timer_datapath.sv - HH:MM:SS:CC up/down time core; lap capture under STOPWATCH_LAP_EN
module stopwatch_timer_datapath #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100,
    parameter int HOUR_MAX = 24
) (
    input  logic                          clk,
    input  logic                          reset,
    stopwatch_timer_datapath_if.slave     bus
);
    localparam int             DIV        = CLK_FREQ / TICK_HZ;
    localparam int             PW         = $clog2(DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);
    localparam logic [4:0]     HOUR_LAST  = 5'(HOUR_MAX - 1);

    logic [PW-1:0] presc_q;
    logic [6:0]    msec_q;
    logic [5:0]    sec_q, min_q;
    logic [4:0]    hour_q;
    logic          done_q, overflow_q, mode_q;
    logic          running, tick;

    logic [6:0]    t_msec;
    logic [5:0]    t_sec, t_min;
    logic [4:0]    t_hour;
    logic          t_ovf, t_done, is_zero;

    assign running = bus.run & ~bus.set_en & ~(bus.mode & done_q);
    assign tick    = running && (presc_q == PRESC_LAST);

    function automatic logic [6:0] fld_step(input logic [6:0] v, input logic [6:0] last,
                                            input logic up);
        if (up)
            return (v == last) ? 7'd0 : v + 7'd1;
        else
            return (v == 7'd0) ? last : v - 7'd1;
    endfunction

    // Whole carry/borrow chain resolves in one cycle so all fields move on the same edge.
    always_comb begin
        t_msec  = msec_q;
        t_sec   = sec_q;
        t_min   = min_q;
        t_hour  = hour_q;
        t_ovf   = 1'b0;
        t_done  = 1'b0;
        is_zero = (msec_q == 7'd0) && (sec_q == 6'd0) && (min_q == 6'd0) && (hour_q == 5'd0);
        if (!bus.mode) begin
            t_msec = (msec_q == 7'd99) ? 7'd0 : msec_q + 7'd1;
            if (msec_q == 7'd99) begin
                t_sec = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
                if (sec_q == 6'd59) begin
                    t_min = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                    if (min_q == 6'd59) begin
                        t_hour = (hour_q == HOUR_LAST) ? 5'd0 : hour_q + 5'd1;
                        t_ovf  = (hour_q == HOUR_LAST);
                    end
                end
            end
        end else if (is_zero) begin
            t_done = 1'b1;
        end else begin
            t_msec = (msec_q == 7'd0) ? 7'd99 : msec_q - 7'd1;
            if (msec_q == 7'd0) begin
                t_sec = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
                if (sec_q == 6'd0) begin
                    t_min = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
                    if (min_q == 6'd0)
                        t_hour = hour_q - 5'd1;
                end
            end
            t_done = (msec_q == 7'd1) && (sec_q == 6'd0) && (min_q == 6'd0) && (hour_q == 5'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q    <= '0;
            msec_q     <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            mode_q     <= bus.mode;
        end else begin
            mode_q     <= bus.mode;
            overflow_q <= 1'b0;
            if (bus.clear) begin
                presc_q <= '0;
                msec_q  <= '0;
                sec_q   <= '0;
                min_q   <= '0;
                hour_q  <= '0;
                done_q  <= 1'b0;
            end else if (bus.set_en) begin
                if (bus.inc ^ bus.dec) begin
                    case (bus.set_sel)
                        2'd0:    msec_q <= fld_step(msec_q, 7'd99, bus.inc);
                        2'd1:    sec_q  <= 6'(fld_step({1'b0, sec_q}, 7'd59, bus.inc));
                        2'd2:    min_q  <= 6'(fld_step({1'b0, min_q}, 7'd59, bus.inc));
                        default: hour_q <= 5'(fld_step({2'b00, hour_q}, {2'b00, HOUR_LAST}, bus.inc));
                    endcase
                end
                if (bus.inc | bus.dec | (bus.mode != mode_q))
                    done_q <= 1'b0;
            end else begin
                if (running)
                    presc_q <= tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    msec_q     <= t_msec;
                    sec_q      <= t_sec;
                    min_q      <= t_min;
                    hour_q     <= t_hour;
                    overflow_q <= t_ovf;
                    if (t_done)
                        done_q <= 1'b1;
                end
                if (bus.mode != mode_q)
                    done_q <= 1'b0;
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic [6:0] lap_msec_q;
    logic [5:0] lap_sec_q, lap_min_q;
    logic [4:0] lap_hour_q;
    logic       lap_valid_q;

    // Captures the register values, i.e. the time before this edge's tick.
    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            lap_msec_q  <= '0;
            lap_sec_q   <= '0;
            lap_min_q   <= '0;
            lap_hour_q  <= '0;
            lap_valid_q <= 1'b0;
        end else if (bus.lap) begin
            lap_msec_q  <= msec_q;
            lap_sec_q   <= sec_q;
            lap_min_q   <= min_q;
            lap_hour_q  <= hour_q;
            lap_valid_q <= 1'b1;
        end
    end

    assign bus.lap_msec  = lap_msec_q;
    assign bus.lap_sec   = lap_sec_q;
    assign bus.lap_min   = lap_min_q;
    assign bus.lap_hour  = lap_hour_q;
    assign bus.lap_valid = lap_valid_q;
`else
    logic unused_lap;
    assign unused_lap    = bus.lap;
    assign bus.lap_msec  = '0;
    assign bus.lap_sec   = '0;
    assign bus.lap_min   = '0;
    assign bus.lap_hour  = '0;
    assign bus.lap_valid = 1'b0;
`endif

    assign bus.msec     = msec_q;
    assign bus.sec      = sec_q;
    assign bus.min      = min_q;
    assign bus.hour     = hour_q;
    assign bus.done     = done_q;
    assign bus.overflow = overflow_q;
    assign bus.running  = running;
endmodule
